// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor. It computes diff = a - b one bit per clock,
// LSB first, using a single full-subtractor cell and a registered borrow.
// This trades latency for area. The block talks to its controller through a
// start/done handshake.
//
// Ports
//   clk         in   1      system clock; all state changes on the rising edge
//   rst         in   1      synchronous, active-high reset
//   start       in   1      operation request; only looked at while ready=1
//   a           in   WIDTH  minuend, captured when start is accepted
//   b           in   WIDTH  subtrahend, captured when start is accepted
//   ready       out  1      high in IDLE or DONE, when a new start is accepted
//   busy        out  1      high while bits are being shifted through
//   done        out  1      one-cycle pulse; result outputs are valid
//   diff        out  WIDTH  a - b mod 2^WIDTH; held until the next result
//   borrow_out  out  1      high when a < b (unsigned)
//   ovf         out  1      two's-complement overflow of a - b
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  // One extra counter bit beyond $clog2(WIDTH), so the count can never wrap
  // during an operation, even when WIDTH is a power of two.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             bit_d;
  logic             borrow_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell acting on the current LSBs of the operand shifters.
  assign bit_d       = sa[0] ^ sb[0] ^ borrow;
  assign borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);

  // Each new difference bit enters at the MSB. After WIDTH shifts, the first
  // (LSB) bit has moved down to bit 0.
  assign res_next = {bit_d, res[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Controller and datapath in one always_ff block. The handshake outputs are
  // registered next to the state, so they change on the same edge as the
  // state. Result outputs are written only on the edge that leaves SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            state  <= SHIFT;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        SHIFT: begin
          res    <= res_next;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            // Overflow only happens when the operand signs differ and the
            // result sign does not match the minuend sign. The result sign
            // is the bit produced in this final cycle.
            diff       <= res_next;
            borrow_out <= borrow_next;
            ovf        <= (a_msb != b_msb) & (bit_d != a_msb);
            state      <= DONE;
            done       <= 1'b1;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor at WIDTH=4. Expected results come
// from a plain-integer arithmetic model (modular difference, unsigned compare,
// signed range test) rather than from any bit-serial formulation.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W     = 4;
  localparam int LIMIT = 20;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] d, output logic bo,
                                output logic ov);
    int ua, ub, sa, sb, sd;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    d  = W'((ua - ub + (1 << W)) % (1 << W));
    bo = (ua < ub);
    sd = sa - sb;
    ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endfunction

  // Present start with the operands for one edge, then scramble a/b so a
  // late change on the inputs would corrupt the result if it leaked in.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Wait a bounded number of cycles for done; report the edges it took.
  task automatic wait_done(output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (cycles >= LIMIT) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got ready/busy/done=%b expected 100", {ready, busy, done});
    end
    checks++;
    if ({diff, borrow_out, ovf} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result: got diff=%h borrow=%b ovf=%b expected all 0", diff, borrow_out, ovf);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got ready/busy/done=%b expected 100", {ready, busy, done});
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{4'h9, 4'h3, 4'h0, 4'h8, 4'h7};
    logic [W-1:0] vb [5] = '{4'h3, 4'h9, 4'h0, 4'h1, 4'hF};
    logic [W-1:0] ed;
    logic         eb, eo;
    int           cyc;
    bit           to;
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], ed, eb, eo);
      accept(va[i], vb[i]);
      checks++;
      if ({ready, busy} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL directed_busy a=%h b=%h: got ready/busy=%b expected 01", va[i], vb[i], {ready, busy});
      end
      wait_done(cyc, to);
      checks++;
      if (to || cyc != W) begin
        errors++;
        $display("[TB] FAIL directed_latency a=%h b=%h: got %0d cycles (timeout=%0b) expected %0d", va[i], vb[i], cyc, to, W);
      end
      checks++;
      if ({diff, borrow_out, ovf} !== {ed, eb, eo}) begin
        errors++;
        $display("[TB] FAIL directed_result a=%h b=%h: got diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b",
                 va[i], vb[i], diff, borrow_out, ovf, ed, eb, eo);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || {diff, borrow_out, ovf} !== {ed, eb, eo}) begin
        errors++;
        $display("[TB] FAIL directed_pulse_hold a=%h b=%h: got done=%b diff=%h expected done=0 diff=%h", va[i], vb[i], done, diff, ed);
      end
    end
  endtask

  task automatic test_ignore_start;
    int cyc, extra;
    bit to;
    accept(4'h5, 4'h2);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'h1;
    b     = 4'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, to);
    checks++;
    if (to || (cyc + 2) != W) begin
      errors++;
      $display("[TB] FAIL ignore_latency: got %0d cycles (timeout=%0b) expected %0d", cyc + 2, to, W);
    end
    checks++;
    if (diff !== 4'h3) begin
      errors++;
      $display("[TB] FAIL ignore_diff: got %h expected 3", diff);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || diff !== 4'h3) begin
      errors++;
      $display("[TB] FAIL ignore_single_done: got %0d extra done pulses, diff=%h expected 0 and 3", extra, diff);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    accept(4'hC, 4'h5);
    wait_done(cyc, to);
    checks++;
    if (to || diff !== 4'h7) begin
      errors++;
      $display("[TB] FAIL b2b_first: got diff=%h (timeout=%0b) expected 7", diff, to);
    end
    accept(4'h2, 4'h7);
    checks++;
    if ({ready, busy, done} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL b2b_no_idle: got ready/busy/done=%b expected 010", {ready, busy, done});
    end
    wait_done(cyc, to);
    checks++;
    if (to || cyc != W) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got %0d cycles (timeout=%0b) expected %0d", cyc, to, W);
    end
    checks++;
    if ({diff, borrow_out, ovf} !== {4'hB, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_result: got diff=%h borrow=%b ovf=%b expected diff=b borrow=1 ovf=0", diff, borrow_out, ovf);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    accept(4'h5, 4'h2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ready, busy, done, diff, borrow_out, ovf} !== {3'b100, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: got ready/busy/done=%b diff=%h borrow=%b ovf=%b expected 100 and zeros",
               {ready, busy, done}, diff, borrow_out, ovf);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || diff !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: got %0d bad cycles, diff=%h expected 0 and 0", seen, diff);
    end
  endtask

  task automatic test_sweep;
    logic [W-1:0] ed, prev;
    logic         eb, eo;
    int           cyc;
    bit           to;
    prev = diff;
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        model(W'(i), W'(j), ed, eb, eo);
        accept(W'(i), W'(j));
        checks++;
        if (diff !== prev) begin
          errors++;
          $display("[TB] FAIL sweep_hold a=%h b=%h: got diff=%h during shift expected %h", W'(i), W'(j), diff, prev);
        end
        wait_done(cyc, to);
        checks++;
        if (to || cyc != W) begin
          errors++;
          $display("[TB] FAIL sweep_latency a=%h b=%h: got %0d cycles (timeout=%0b) expected %0d", W'(i), W'(j), cyc, to, W);
        end
        checks++;
        if ({diff, borrow_out, ovf} !== {ed, eb, eo}) begin
          errors++;
          $display("[TB] FAIL sweep_result a=%h b=%h: got diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b",
                   W'(i), W'(j), diff, borrow_out, ovf, ed, eb, eo);
        end
        prev = ed;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
